// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the instruction-fetch and data requesters.
// Data has priority; a consecutive-data-grant counter forces a fetch through.
module mem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err
);

  localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     dstreak_q, dstreak_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              op_write_q, op_write_d;

  logic access, owner_req, in_d, in_i;

  assign access = (ramstate == RS_ACCESS);

  always_comb begin
    state_d    = state_q;
    dstreak_d  = dstreak_q;
    tcnt_d     = tcnt_q;
    err_d      = err_q;
    addr_d     = addr_q;
    data_d     = data_q;
    op_write_d = op_write_q;
    owner_req  = (state_q == DGRANT) ? (op_write_q ? dWEN : dREN) : iREN;
    case (state_q)
      IDLE: begin
        if ((dREN || dWEN) && !(iREN && dstreak_q == SW'(MAX_DSTREAK))) begin
          state_d    = DGRANT;
          addr_d     = daddr;
          data_d     = dstore;
          op_write_d = dWEN;
          tcnt_d     = '0;
          if (!iREN)
            dstreak_d = '0;
          else if (dstreak_q != SW'(MAX_DSTREAK))
            dstreak_d = dstreak_q + SW'(1);
        end else if (iREN) begin
          state_d   = IGRANT;
          addr_d    = iaddr;
          tcnt_d    = '0;
          dstreak_d = '0;
        end
      end
      DGRANT, IGRANT: begin
        // Completion outranks every abort cause, including a same-cycle timeout.
        if (access) begin
          state_d = IDLE;
        end else if (ramstate == RS_ERROR) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (!owner_req) begin
          state_d = IDLE;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      dstreak_q  <= '0;
      tcnt_q     <= '0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      op_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dstreak_q  <= dstreak_d;
      tcnt_q     <= tcnt_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      op_write_q <= op_write_d;
    end
  end

  // Outputs are forced idle while RST is high, before the reset edge lands.
  always_comb begin
    in_d     = (state_q == DGRANT) && !RST;
    in_i     = (state_q == IGRANT) && !RST;
    ramREN   = (in_d && !op_write_q) || in_i;
    ramWEN   = in_d && op_write_q;
    ramaddr  = (in_d || in_i) ? addr_q : '0;
    ramstore = in_d ? data_q : '0;
    dwait    = !(in_d && access);
    iwait    = !(in_i && access);
    dload    = (in_d && !op_write_q && access) ? ramload : '0;
    iload    = (in_i && access) ? ramload : '0;
  end

  assign err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch, contention, starvation,
// wait states, timeout, RAM error, request drop and mid-grant reset.
module tb_mem_arbiter;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4), .TIMEOUT(64)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven, checks follow #4 later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

    // Reset held two cycles with a pending fetch
    tick();
    iREN = 1'b1; iaddr = 32'h40; ramstate = ACCESS; ramload = 32'hDEADBEEF;
    settle();
    check("rst_iwait", iwait, 1); check("rst_ramREN", ramREN, 0);
    check("rst_err", err, 0); check("rst_dwait", dwait, 1); check("rst_iload", iload, 0);
    tick();
    settle();
    check("rst2_ramREN", ramREN, 0); check("rst2_ramaddr", ramaddr, 0);
    tick();
    RST = 1'b0;
    settle();
    check("post_rst_idle", ramREN, 0);

    // Zero-wait fetch
    tick();
    settle();
    check("fetch_ramREN", ramREN, 1); check("fetch_ramWEN", ramWEN, 0);
    check("fetch_addr", ramaddr, 32'h40); check("fetch_iwait", iwait, 0);
    check("fetch_iload", iload, 32'hDEADBEEF); check("fetch_dwait", dwait, 1);
    tick();
    iREN = 1'b0;
    settle();
    check("fetch_idle_ramREN", ramREN, 0); check("fetch_idle_iwait", iwait, 1);
    check("fetch_idle_iload", iload, 0);

    // Contention: data wins, and keeps winning while dREN is held
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h100; ramload = 32'h1111;
    tick();
    settle();
    check("cont_daddr", ramaddr, 32'h100); check("cont_dwait", dwait, 0);
    check("cont_dload", dload, 32'h1111); check("cont_iwait", iwait, 1);
    check("cont_ramREN", ramREN, 1); check("cont_iload", iload, 0);
    tick();
    settle();
    check("cont_idle", ramREN, 0);
    tick();
    settle();
    check("cont_d2_addr", ramaddr, 32'h100); check("cont_d2_dwait", dwait, 0);
    tick();
    dREN = 1'b0;
    settle();
    check("cont_idle2", ramREN, 0);
    tick();
    settle();
    check("cont_i_addr", ramaddr, 32'h80); check("cont_i_iwait", iwait, 0);
    tick();
    iREN = 1'b0;

    // Starvation: D D D D I D D D D I with writes held and fetch pending
    dWEN = 1'b1; daddr = 32'h200; iREN = 1'b1; iaddr = 32'h300;
    for (int k = 0; k < 10; k++) begin
      dstore = 32'hCAFE0000 + k;
      tick();
      settle();
      if (k == 4 || k == 9) begin
        check($sformatf("starve_i%0d_ramREN", k), ramREN, 1);
        check($sformatf("starve_i%0d_ramWEN", k), ramWEN, 0);
        check($sformatf("starve_i%0d_addr", k), ramaddr, 32'h300);
        check($sformatf("starve_i%0d_iwait", k), iwait, 0);
      end else begin
        check($sformatf("starve_d%0d_ramWEN", k), ramWEN, 1);
        check($sformatf("starve_d%0d_ramREN", k), ramREN, 0);
        check($sformatf("starve_d%0d_addr", k), ramaddr, 32'h200);
        check($sformatf("starve_d%0d_store", k), ramstore, 32'hCAFE0000 + k);
        check($sformatf("starve_d%0d_dwait", k), dwait, 0);
        check($sformatf("starve_d%0d_dload", k), dload, 0);
      end
      tick();
      if (k == 9) begin dWEN = 1'b0; iREN = 1'b0; end
    end
    settle();
    check("starve_idle", ramREN | ramWEN, 0);

    // Wait states: 3 BUSY cycles then ACCESS
    dREN = 1'b1; daddr = 32'h400; ramstate = BUSY; ramload = 32'h5555AAAA;
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("ws%0d_dwait", i), dwait, 1);
      check($sformatf("ws%0d_ramREN", i), ramREN, 1);
      check($sformatf("ws%0d_addr", i), ramaddr, 32'h400);
      tick();
    end
    ramstate = ACCESS;
    settle();
    check("ws_done_dwait", dwait, 0); check("ws_done_dload", dload, 32'h5555AAAA);
    check("ws_done_addr", ramaddr, 32'h400);
    tick();
    dREN = 1'b0; ramstate = FREE;
    settle();
    check("ws_idle_dwait", dwait, 1); check("ws_idle_ramREN", ramREN, 0);

    // Timeout: BUSY for the whole grant window
    dREN = 1'b1; daddr = 32'h500; ramstate = BUSY;
    tick();
    for (int k = 0; k < 64; k++) begin
      settle();
      if (dwait !== 1'b1 || ramREN !== 1'b1) check($sformatf("to%0d_grant", k), {dwait, ramREN}, 2'b11);
      if (k == 63) check("to_last_err", err, 0);
      tick();
    end
    dREN = 1'b0;
    settle();
    check("to_err", err, 1); check("to_idle", ramREN, 0); check("to_dwait", dwait, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    settle();
    check("to_rst_err", err, 0);

    // RAM ERROR status
    dREN = 1'b1; daddr = 32'h600; ramstate = ERROR;
    tick();
    settle();
    check("er_grant", ramREN, 1); check("er_err0", err, 0); check("er_dwait", dwait, 1);
    tick();
    dREN = 1'b0; ramstate = FREE;
    settle();
    check("er_err1", err, 1); check("er_idle", ramREN, 0);
    tick(); tick(); tick();
    settle();
    check("er_sticky", err, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    settle();
    check("er_rst", err, 0);

    // Request drop aborts without a pulse
    dREN = 1'b1; daddr = 32'h700; ramstate = BUSY;
    tick();
    dREN = 1'b0;
    settle();
    check("drop_grant", ramREN, 1); check("drop_dwait", dwait, 1);
    tick();
    settle();
    check("drop_idle", ramREN, 0); check("drop_err", err, 0);

    // ACCESS coinciding with a drop still completes
    dREN = 1'b1; daddr = 32'h710; ramload = 32'h0BADF00D;
    tick();
    dREN = 1'b0; ramstate = ACCESS;
    settle();
    check("dropacc_dwait", dwait, 0); check("dropacc_dload", dload, 32'h0BADF00D);
    tick();
    ramstate = FREE;

    // Reset during a grant abandons it silently
    dREN = 1'b1; daddr = 32'h800; ramstate = BUSY;
    tick();
    settle();
    check("mr_grant", ramaddr, 32'h800);
    #1;
    RST = 1'b1; ramstate = ACCESS;
    #1;
    check("mr_dwait", dwait, 1); check("mr_ramREN", ramREN, 0); check("mr_dload", dload, 0);
    tick();
    RST = 1'b0; dREN = 1'b0; ramstate = FREE;
    settle();
    check("mr_idle", ramREN, 0); check("mr_err", err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory controller. Sits between the datapath caches and the shared RAM.
- Arbitrates the instruction-fetch and data requesters onto one RAM port and sequences each access until RAM reports ACCESS.
- Returns hit/wait handshakes to each requester.
- Data side has priority; an anti-starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits.
- MAX_DSTREAK, 4, consecutive data grants allowed while iREN is pending before one instruction grant is forced.
- TIMEOUT, 64, cycles a grant may wait for ACCESS before it is aborted.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset. One clock; reset is synchronous and active-high.
- iREN  in  1  instruction read request; held until iwait=0.
- iaddr  in  ADDR_W  instruction address.
- iwait  out  1  low for exactly one cycle when iload is valid.
- iload  out  DATA_W  instruction read data.
- dREN  in  1  data read request.
- dWEN  in  1  data write request. dREN and dWEN are never both high.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  data write value.
- dwait  out  1  low for exactly one cycle on data completion.
- dload  out  DATA_W  data read value.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- err  out  1  sticky error flag.

Behaviour:
- States: IDLE, DGRANT, IGRANT.
- Reset (RST sampled high at a CLK edge): state=IDLE, dstreak=0, tcnt=0, err=0, latched addr/data=0. Synchronous only.
- Outputs while reset is in effect and in IDLE: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
- Reset mid-grant abandons the access. No wait-low pulse is issued.
- IDLE arbitration, evaluated each cycle:
  - If (dREN|dWEN) and not (iREN and dstreak==MAX_DSTREAK): go to DGRANT. Latch daddr, dstore, and op (read/write).
  - Else if iREN: go to IGRANT, latch iaddr.
  - Else stay in IDLE.
- dstreak updates on the IDLE->grant transition:
  - +1 on each DGRANT entry when iREN is high (saturates at MAX_DSTREAK).
  - Cleared on IGRANT entry, and on a DGRANT entry when iREN is low.
- Grant states drive the latched address and data to the RAM, combinationally from state:
  - DGRANT: ramREN=op_read, ramWEN=op_write, ramstore=latched dstore.
  - IGRANT: ramREN=1, ramWEN=0.
- Completion: ramstate==ACCESS in a grant state.
  - Drive the owner's wait low that cycle.
  - Pass ramload to dload (DGRANT read) or iload (IGRANT). The load output is 0 otherwise.
  - Next state is IDLE.
  - Minimum latency: request seen in IDLE at cycle N -> wait low at N+1 (zero-wait RAM). Next arbitration at N+2.
- ramstate==BUSY or FREE in a grant state: hold the state, increment tcnt.
- ramstate==ERROR in a grant state: set err, go to IDLE. No wait pulse is issued and the requester retries naturally.
- Timeout:
  - tcnt reaches TIMEOUT-1 without ACCESS: set err, go to IDLE.
  - tcnt clears on every grant entry.
- Request dropped during a grant (owner's REN/WEN low): abort to IDLE next cycle. No pulse, err unaffected.
- Simultaneous events:
  - ACCESS and request drop in the same cycle: completion wins and the pulse is issued.
  - ACCESS takes priority over the timeout when both occur on the final cycle.
- err clears only on reset.
- Grants never overlap. ramREN and ramWEN are never both high.

Test Plan:
- Reset: RST=1 for 2 cycles with iREN=1 -> iwait=1, ramREN=0, err=0. First grant appears the cycle after RST falls.
- Zero-wait fetch: iREN=1, iaddr=0x40, ramstate=ACCESS, ramload=0xDEADBEEF -> IGRANT next cycle, ramaddr=0x40, iwait=0 one cycle, iload=0xDEADBEEF, then IDLE.
- Contention: iREN=1 and dREN=1 (daddr=0x100) in the same cycle -> DGRANT first. After dwait pulse, the next grant goes back to data while dREN remains high.
- Starvation: dWEN held high continuously with iREN=1, MAX_DSTREAK=4 -> exactly 4 data writes (ramWEN=1, ramstore=dstore), then one IGRANT, then data resumes.
- Wait states: ramstate=BUSY for 3 cycles then ACCESS during a read -> dwait low exactly on the 4th grant cycle. ramREN and ramaddr are stable throughout.
- Errors: ramstate=BUSY for 64 cycles -> err=1, state IDLE, no dwait pulse. A separate run with ramstate=ERROR -> err=1 the next cycle, and err stays set until RST.
